// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Round-robin data-memory controller for two requesters. Handles
//            sign/zero-extended sub-word loads and read-modify-write sub-word
//            stores.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_wdata_i,
    input  logic        req0_we_i,
    input  logic [1:0]  req0_size_i,
    input  logic        req0_unsigned_i,
    output logic        rsp0_valid_o,
    output logic [31:0] rsp0_rdata_o,
    output logic        rsp0_err_o,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_wdata_i,
    input  logic        req1_we_i,
    input  logic [1:0]  req1_size_i,
    input  logic        req1_unsigned_i,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp1_rdata_o,
    output logic        rsp1_err_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rdata_i
);

    typedef logic [31:0] bus32_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b10;

    state_t     r_state;
    logic       r_last_grant;
    logic       r_port;
    bus32_t     r_addr;
    bus32_t     r_wdata;
    bus32_t     r_old;
    bus32_t     r_rdata;
    logic       r_we;
    logic [1:0] r_size;
    logic       r_uns;
    logic       r_err;

    logic       w_grant0;
    logic       w_grant1;
    logic       w_err;
    bus32_t     w_byte_shift;
    bus32_t     w_half_shift;
    bus32_t     w_load;
    bus32_t     w_merge;
    bus32_t     w_word_addr;

    // A tie goes to the port that did not win last time.
    assign w_grant0 = (r_state == S_IDLE) && req0_valid_i && (!req1_valid_i || r_last_grant);
    assign w_grant1 = (r_state == S_IDLE) && req1_valid_i && (!req0_valid_i || !r_last_grant);

    assign req0_ready_o = w_grant0 && !rst_i;
    assign req1_ready_o = w_grant1 && !rst_i;

    assign w_err = (r_size == 2'b11)
                || ((r_size == C_SZ_HALF) && r_addr[0])
                || ((r_size == C_SZ_WORD) && (r_addr[1:0] != 2'b00));

    assign w_word_addr  = {r_addr[31:2], 2'b00};
    assign w_byte_shift = mem_rdata_i >> {r_addr[1:0], 3'b000};
    assign w_half_shift = mem_rdata_i >> {r_addr[1], 4'b0000};

    always_comb begin
        w_load = mem_rdata_i;
        case (r_size)
            C_SZ_BYTE: w_load = r_uns ? {24'd0, w_byte_shift[7:0]}
                                      : {{24{w_byte_shift[7]}}, w_byte_shift[7:0]};
            C_SZ_HALF: w_load = r_uns ? {16'd0, w_half_shift[15:0]}
                                      : {{16{w_half_shift[15]}}, w_half_shift[15:0]};
            default:   w_load = mem_rdata_i;
        endcase
    end

    always_comb begin
        w_merge = r_old;
        if (r_size == C_SZ_BYTE) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    // Memory write enable is gated by reset so an abandoned store never lands.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        case (r_state)
            S_ACCESS: begin
                mem_addr_o = w_word_addr;
                if (!w_err && r_we && (r_size == C_SZ_WORD)) begin
                    mem_wdata_o = r_wdata;
                    mem_we_o    = !rst_i;
                end
            end
            S_WRITE: begin
                mem_addr_o  = w_word_addr;
                mem_wdata_o = w_merge;
                mem_we_o    = !rst_i;
            end
            default: ;
        endcase
    end

    assign rsp0_valid_o = (r_state == S_RESP) && !r_port && !rst_i;
    assign rsp1_valid_o = (r_state == S_RESP) &&  r_port && !rst_i;
    assign rsp0_rdata_o = rsp0_valid_o ? r_rdata : '0;
    assign rsp1_rdata_o = rsp1_valid_o ? r_rdata : '0;
    assign rsp0_err_o   = rsp0_valid_o && r_err;
    assign rsp1_err_o   = rsp1_valid_o && r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_old        <= '0;
            r_rdata      <= '0;
            r_we         <= 1'b0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_port       <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_addr       <= w_grant1 ? req1_addr_i     : req0_addr_i;
                        r_wdata      <= w_grant1 ? req1_wdata_i    : req0_wdata_i;
                        r_we         <= w_grant1 ? req1_we_i       : req0_we_i;
                        r_size       <= w_grant1 ? req1_size_i     : req0_size_i;
                        r_uns        <= w_grant1 ? req1_unsigned_i : req0_unsigned_i;
                        r_err        <= 1'b0;
                        r_rdata      <= '0;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (w_err) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= S_RESP;
                    end else if (!r_we) begin
                        r_rdata <= w_load;
                        r_state <= S_RESP;
                    end else if (r_size == C_SZ_WORD) begin
                        r_state <= S_RESP;
                    end else begin
                        r_old   <= mem_rdata_i;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
